// File: rtl/p_sa_sync_pkg.sv
// Shared helpers for the p_sa synchroniser family: counter sizing and
// parameter legality used by every synchroniser variant.
package p_sa_sync_pkg;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit params_ok(input int depth, input int filt);
        return (depth >= 2) && (filt >= 1);
    endfunction

endpackage

// File: rtl/p_sa_ssync_ch.sv
// One channel of the filtered level synchroniser: flop chain, stability
// counter, accepted level q and registered rise/fall pulses.
module p_sa_ssync_ch
    import p_sa_sync_pkg::*;
#(
    parameter int   DEPTH   = 3,
    parameter int   FILT    = 4,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic chg_nxt
);

    localparam int               CNT_W    = clog2(FILT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT - 1);

    if (!params_ok(DEPTH, FILT)) begin : g_bad_params
        $error("p_sa_ssync_ch: DEPTH must be >= 2 and FILT must be >= 1");
    end

    (* ASYNC_REG = "TRUE" *) logic [DEPTH-1:0] chain;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             accept;

    assign s       = chain[DEPTH-1];
    assign accept  = (s != q) && (cnt == CNT_LAST);
    assign chg_nxt = accept;

    // The counter only ever measures one uninterrupted run of s differing from q.
    always_ff @(posedge clk) begin
        if (clr) begin
            chain <= {DEPTH{RST_VAL}};
            q     <= RST_VAL;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[DEPTH-2:0], d};
            rise  <= accept && s;
            fall  <= accept && !s;
            if (s == q) begin
                cnt <= '0;
            end else if (accept) begin
                q   <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/p_sa_ssync_nch_filt.sv
// NUM_CH independent filtered synchronisers with edge pulses and a single
// registered "something changed" flag.
module p_sa_ssync_nch_filt
    import p_sa_sync_pkg::*;
#(
    parameter int                NUM_CH  = 8,
    parameter int                DEPTH   = 3,
    parameter int                FILT    = 4,
    parameter logic [NUM_CH-1:0] RST_VAL = {NUM_CH{1'b0}}
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [NUM_CH-1:0] d,
    output logic [NUM_CH-1:0] q,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic              any_chg
);

    if ((NUM_CH < 1) || !params_ok(DEPTH, FILT)) begin : g_bad_params
        $error("p_sa_ssync_nch_filt: need NUM_CH >= 1, DEPTH >= 2, FILT >= 1");
    end

    logic [NUM_CH-1:0] chg_nxt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        p_sa_ssync_ch #(
            .DEPTH  (DEPTH),
            .FILT   (FILT),
            .RST_VAL(RST_VAL[i])
        ) u_ch (
            .clk    (clk),
            .clr    (clr),
            .d      (d[i]),
            .q      (q[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .chg_nxt(chg_nxt[i])
        );
    end

    // Built from the channels' next-state terms so it lands on the same cycle as the pulses.
    always_ff @(posedge clk) begin
        if (clr) begin
            any_chg <= 1'b0;
        end else begin
            any_chg <= |chg_nxt;
        end
    end

endmodule

// File: tb/tb_p_sa_ssync_nch_filt.sv
// Three configurations of p_sa_ssync_nch_filt driven with shared inputs and
// compared every cycle against a history-based reference model.
module tb_p_sa_ssync_nch_filt;

    localparam int NI = 3;
    localparam int DEP_A = 3, FLT_A = 4;
    localparam int DEP_B = 2, FLT_B = 1;
    localparam int DEP_C = 3, FLT_C = 8;
    localparam logic [7:0] RST_A = 8'hA5;
    localparam logic [7:0] RST_B = 8'h00;
    localparam logic [7:0] RST_C = 8'h3C;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] d   = 8'hA5;

    always #5 clk = ~clk;

    logic [7:0] q_a, rise_a, fall_a;
    logic [7:0] q_b, rise_b, fall_b;
    logic [7:0] q_c, rise_c, fall_c;
    logic       any_a, any_b, any_c;

    p_sa_ssync_nch_filt #(.NUM_CH(8), .DEPTH(DEP_A), .FILT(FLT_A), .RST_VAL(RST_A)) dut_a (
        .clk(clk), .clr(clr), .d(d), .q(q_a), .rise(rise_a), .fall(fall_a), .any_chg(any_a));
    p_sa_ssync_nch_filt #(.NUM_CH(8), .DEPTH(DEP_B), .FILT(FLT_B), .RST_VAL(RST_B)) dut_b (
        .clk(clk), .clr(clr), .d(d), .q(q_b), .rise(rise_b), .fall(fall_b), .any_chg(any_b));
    p_sa_ssync_nch_filt #(.NUM_CH(8), .DEPTH(DEP_C), .FILT(FLT_C), .RST_VAL(RST_C)) dut_c (
        .clk(clk), .clr(clr), .d(d), .q(q_c), .rise(rise_c), .fall(fall_c), .any_chg(any_c));

    // Model: history of sampled d per instance, accepted level, and how many
    // consecutive edges the synchronised value has sat on the other side of q.
    int         dep  [NI] = '{DEP_A, DEP_B, DEP_C};
    int         flt  [NI] = '{FLT_A, FLT_B, FLT_C};
    logic [7:0] rstv [NI] = '{RST_A, RST_B, RST_C};
    logic [7:0] hist [NI][4];
    logic [7:0] mq   [NI];
    logic [7:0] mrise[NI];
    logic [7:0] mfall[NI];
    int         away [NI][8];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int k, input logic clr_v, input logic [7:0] d_v);
        logic [7:0] s;
        if (clr_v) begin
            for (int j = 0; j < 4; j++) hist[k][j] = rstv[k];
            mq[k]    = rstv[k];
            mrise[k] = 8'h00;
            mfall[k] = 8'h00;
            for (int c = 0; c < 8; c++) away[k][c] = 0;
        end else begin
            s        = hist[k][dep[k]-1];
            mrise[k] = 8'h00;
            mfall[k] = 8'h00;
            for (int c = 0; c < 8; c++) begin
                if (s[c] == mq[k][c]) begin
                    away[k][c] = 0;
                end else begin
                    away[k][c] = away[k][c] + 1;
                    if (away[k][c] >= flt[k]) begin
                        mq[k][c] = s[c];
                        if (s[c]) mrise[k][c] = 1'b1;
                        else      mfall[k][c] = 1'b1;
                        away[k][c] = 0;
                    end
                end
            end
            for (int j = 3; j > 0; j--) hist[k][j] = hist[k][j-1];
            hist[k][0] = d_v;
        end
    endtask

    task automatic checkOutput();
        check_val("q_a",    q_a,    mq[0]);
        check_val("rise_a", rise_a, mrise[0]);
        check_val("fall_a", fall_a, mfall[0]);
        check_val("any_a",  {7'b0, any_a}, {7'b0, |(mrise[0] | mfall[0])});
        check_val("q_b",    q_b,    mq[1]);
        check_val("rise_b", rise_b, mrise[1]);
        check_val("fall_b", fall_b, mfall[1]);
        check_val("any_b",  {7'b0, any_b}, {7'b0, |(mrise[1] | mfall[1])});
        check_val("q_c",    q_c,    mq[2]);
        check_val("rise_c", rise_c, mrise[2]);
        check_val("fall_c", fall_c, mfall[2]);
        check_val("any_c",  {7'b0, any_c}, {7'b0, |(mrise[2] | mfall[2])});
    endtask

    task automatic tick();
        logic       clr_s;
        logic [7:0] d_s;
        clr_s = clr;
        d_s   = d;
        @(posedge clk);
        for (int k = 0; k < NI; k++) model_step(k, clr_s, d_s);
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input logic clr_v, input logic [7:0] d_v, input int n);
        clr = clr_v;
        d   = d_v;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n_rise;
        int n_fall;
        logic [7:0] nd;

        for (int k = 0; k < NI; k++) begin
            for (int j = 0; j < 4; j++) hist[k][j] = rstv[k];
            mq[k]    = rstv[k];
            mrise[k] = 8'h00;
            mfall[k] = 8'h00;
            for (int c = 0; c < 8; c++) away[k][c] = 0;
        end

        $display("[TB] reset with d held at reset level");
        applyStimulus(1'b1, 8'hA5, 2);
        clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_val("rst_q_a",    q_a, 8'hA5);
            check_val("rst_rise_a", rise_a | fall_a, 8'h00);
            check_val("rst_any_a",  {7'b0, any_a}, 8'h00);
        end

        $display("[TB] latency on channel 0");
        applyStimulus(1'b0, 8'hA4, 20);
        d = 8'hA5;
        for (int n = 0; n < 8; n++) begin
            tick();
            check_val("lat_rise0", {7'b0, rise_a[0]}, (n == 6) ? 8'h01 : 8'h00);
            check_val("lat_any",   {7'b0, any_a},     (n == 6) ? 8'h01 : 8'h00);
            check_val("lat_q0",    {7'b0, q_a[0]},    (n >= 6) ? 8'h01 : 8'h00);
        end

        $display("[TB] glitch shorter than filter on channel 2");
        applyStimulus(1'b0, 8'hA1, 20);
        applyStimulus(1'b0, 8'hA5, 3);
        d = 8'hA1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_val("glitch_q2",    {7'b0, q_a[2]}, 8'h00);
            check_val("glitch_edge2", {6'b0, rise_a[2], fall_a[2]}, 8'h00);
        end

        $display("[TB] pulse equal to filter on channel 2");
        applyStimulus(1'b0, 8'hA5, 4);
        d = 8'hA1;
        n_rise = 0;
        n_fall = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (rise_a[2]) n_rise++;
            if (fall_a[2]) n_fall++;
        end
        check_val("pulse4_rises", 8'(n_rise), 8'd1);
        check_val("pulse4_falls", 8'(n_fall), 8'd1);

        $display("[TB] bypass toggling on channel 1");
        applyStimulus(1'b0, 8'hA1, 10);
        for (int i = 0; i < 16; i++) begin
            d[1] = ~d[1];
            tick();
            if (i >= 2) begin
                check_val("byp_q1",    {7'b0, q_b[1]}, {7'b0, d[1]});
                check_val("byp_edge1", {7'b0, rise_b[1] | fall_b[1]}, 8'h01);
            end
        end

        $display("[TB] reset in the middle of a count on channel 3");
        applyStimulus(1'b0, 8'hA9, 20);
        applyStimulus(1'b0, 8'hA1, 8);
        applyStimulus(1'b1, 8'hA1, 1);
        check_val("midrst_q3",    {7'b0, q_c[3]}, {7'b0, RST_C[3]});
        check_val("midrst_edge3", {6'b0, rise_c[3], fall_c[3]}, 8'h00);
        clr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_val("midrst_fall3", {7'b0, fall_c[3]}, (i == 10) ? 8'h01 : 8'h00);
        end

        $display("[TB] all channels rise together");
        applyStimulus(1'b1, 8'h00, 1);
        clr = 1'b0;
        d   = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("ind_rise_b", rise_b, (i == 2) ? 8'hFF : 8'h00);
            check_val("ind_any_b",  {7'b0, any_b}, (i == 2) ? 8'h01 : 8'h00);
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 80; i++) begin
            nd = d;
            for (int c = 0; c < 8; c++) begin
                if ($urandom_range(3) == 0) nd[c] = ~nd[c];
            end
            applyStimulus(($urandom_range(40) == 0), nd, int'($urandom_range(10, 1)));
        end
        applyStimulus(1'b0, d, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
